bsg_dmc_ui_arbiter: RTL and testbench



---
 rtl/bsg_dmc_pkg.sv | 25 ++
 rtl/bsg_arb_round_robin.sv | 40 ++++
 rtl/bsg_fifo_1r1w_small.sv | 57 +++++
 rtl/bsg_dmc_ui_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_bsg_dmc_ui_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_dmc_pkg.sv
// bsg_dmc_pkg
// Shared types for the bsg_dmc user-interface (app_*) side.
//   app_cmd_e              : app_cmd encoding (WR, RD, WP, RP)
//   bsg_dmc_ui_arb_state_e : control states of bsg_dmc_ui_arbiter
//   bsg_dmc_cmd_is_write() : 1 for write-class commands (WR, WP), which carry a data burst
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    WR = 3'b000,
    RD = 3'b001,
    WP = 3'b010,
    RP = 3'b011
  } app_cmd_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_CMD   = 2'b01,
    ARB_WDATA = 2'b10
  } bsg_dmc_ui_arb_state_e;

  function automatic logic bsg_dmc_cmd_is_write(input app_cmd_e cmd);
    return (cmd == WR) || (cmd == WP);
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin
// Combinational round-robin picker. The search starts at ptr_i and wraps,
// so the caller owns the priority pointer and decides when it advances.
//   reqs_i   : request vector
//   ptr_i    : index with highest priority this cycle
//   grants_o : one-hot grant (all zero when nothing requests)
//   tag_o    : index of the granted requester
//   v_o      : some requester was granted
module bsg_arb_round_robin #(
  parameter  int width_p     = 4,
  localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic [width_p-1:0]     reqs_i,
  input  logic [lg_width_lp-1:0] ptr_i,
  output logic [width_p-1:0]     grants_o,
  output logic [lg_width_lp-1:0] tag_o,
  output logic                   v_o
);

  int                   idx;
  logic [lg_width_lp-1:0] idx_l;

  always_comb begin
    grants_o = '0;
    tag_o    = '0;
    v_o      = 1'b0;
    idx      = 0;
    idx_l    = '0;
    for (int i = 0; i < width_p; i++) begin
      idx   = (int'(ptr_i) + i) % width_p;
      idx_l = lg_width_lp'(idx);
      if (!v_o && reqs_i[idx_l]) begin
        v_o             = 1'b1;
        grants_o[idx_l] = 1'b1;
        tag_o           = idx_l;
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small
// Small register-based FIFO with valid/ready on the write side and
// valid/yumi on the read side. ready_o and v_o come straight from the
// registered occupancy count.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   v_i, data_i    : push request and data (ignored while full)
//   ready_o        : not full
//   v_o, data_o    : head valid and head data
//   yumi_i         : pop head (ignored while empty)
module bsg_fifo_1r1w_small #(
  parameter  int width_p        = 2,
  parameter  int els_p          = 8,
  localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      enq, deq;

  assign ready_o = (count_r != count_width_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq)
        wptr_r <= (wptr_r == ptr_width_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (deq)
        rptr_r <= (rptr_r == ptr_width_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      count_r <= count_r + count_width_lp'(enq) - count_width_lp'(deq);
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_dmc_ui_arbiter.sv
// bsg_dmc_ui_arbiter
// Shares one bsg_dmc app_* port among num_clients_p requesters. Whole
// transactions are granted round-robin: the command is issued, then for
// writes the full burst is streamed from the granted client. Read bursts are
// routed back to their issuers in order using a FIFO of client ids.
//   ui_clk_i, ui_reset_i            : clock, asynchronous active-high reset
//   client_v_i/cmd_i/addr_i         : per-client command request
//   client_yumi_o                   : one-hot, one-cycle command accept
//   client_wdata_v_i/wdata_i/wmask_i: per-client write beats
//   client_wdata_yumi_o             : write beat consumed
//   client_rdata_v_o                : one-hot read beat valid
//   client_rdata_o/rdata_last_o     : shared read data and last-beat flag
//   app_*                           : bsg_dmc user interface
module bsg_dmc_ui_arbiter
  import bsg_dmc_pkg::*;
#(
  parameter  int num_clients_p      = 4,
  parameter  int ui_addr_width_p    = 28,
  parameter  int ui_data_width_p    = 32,
  parameter  int burst_data_width_p = 128,
  parameter  int rd_tag_depth_p     = 8,
  localparam int lg_clients_lp      = $clog2(num_clients_p),
  localparam int mask_width_lp      = ui_data_width_p / 8,
  localparam int burst_len_lp       = burst_data_width_p / ui_data_width_p,
  localparam int beat_width_lp      = (burst_len_lp > 1) ? $clog2(burst_len_lp) : 1
) (
  input  logic                                           ui_clk_i,
  input  logic                                           ui_reset_i,

  input  logic     [num_clients_p-1:0]                   client_v_i,
  input  app_cmd_e [num_clients_p-1:0]                   client_cmd_i,
  input  logic     [num_clients_p-1:0][ui_addr_width_p-1:0] client_addr_i,
  output logic     [num_clients_p-1:0]                   client_yumi_o,

  input  logic     [num_clients_p-1:0]                   client_wdata_v_i,
  input  logic     [num_clients_p-1:0][ui_data_width_p-1:0] client_wdata_i,
  input  logic     [num_clients_p-1:0][mask_width_lp-1:0] client_wmask_i,
  output logic     [num_clients_p-1:0]                   client_wdata_yumi_o,

  output logic     [num_clients_p-1:0]                   client_rdata_v_o,
  output logic     [ui_data_width_p-1:0]                 client_rdata_o,
  output logic                                           client_rdata_last_o,

  output logic                                           app_en_o,
  output app_cmd_e                                       app_cmd_o,
  output logic     [ui_addr_width_p-1:0]                 app_addr_o,
  input  logic                                           app_rdy_i,

  output logic                                           app_wdf_wren_o,
  output logic     [ui_data_width_p-1:0]                 app_wdf_data_o,
  output logic     [mask_width_lp-1:0]                   app_wdf_mask_o,
  output logic                                           app_wdf_end_o,
  input  logic                                           app_wdf_rdy_i,

  input  logic                                           app_rd_data_valid_i,
  input  logic     [ui_data_width_p-1:0]                 app_rd_data_i,
  input  logic                                           app_rd_data_end_i
);

  bsg_dmc_ui_arb_state_e state_r, state_n;

  logic [lg_clients_lp-1:0]   id_r;
  logic [lg_clients_lp-1:0]   rr_r;
  app_cmd_e                   cmd_r;
  logic [ui_addr_width_p-1:0] addr_r;
  logic [beat_width_lp-1:0]   beat_r;

  logic [num_clients_p-1:0]   eligible;
  logic [num_clients_p-1:0]   arb_grants;
  logic [lg_clients_lp-1:0]   arb_id;
  logic                       arb_v;

  logic                       cmd_accept, wbeat_accept, last_beat;
  logic                       tag_push, tag_pop, tag_ready, tag_v;
  logic [lg_clients_lp-1:0]   tag_head;

  // Read-class requests wait while the tag FIFO is full. The registered full
  // flag is enough: nothing else can push between a grant and its command accept.
  always_comb begin
    eligible = client_v_i;
    for (int i = 0; i < num_clients_p; i++) begin
      if (!tag_ready && !bsg_dmc_cmd_is_write(client_cmd_i[i]))
        eligible[i] = 1'b0;
    end
  end

  bsg_arb_round_robin #(
    .width_p (num_clients_p)
  ) arb (
    .reqs_i   (eligible),
    .ptr_i    (rr_r),
    .grants_o (arb_grants),
    .tag_o    (arb_id),
    .v_o      (arb_v)
  );

  assign cmd_accept   = (state_r == ARB_CMD) & app_rdy_i;
  assign wbeat_accept = (state_r == ARB_WDATA) & client_wdata_v_i[id_r] & app_wdf_rdy_i;
  assign last_beat    = (beat_r == beat_width_lp'(burst_len_lp - 1));

  always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
    if (ui_reset_i) state_r <= ARB_IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      ARB_IDLE:  if (arb_v) state_n = ARB_CMD;
      ARB_CMD:   if (app_rdy_i)
                   state_n = bsg_dmc_cmd_is_write(cmd_r) ? ARB_WDATA : ARB_IDLE;
      ARB_WDATA: if (wbeat_accept && last_beat) state_n = ARB_IDLE;
      default:   state_n = ARB_IDLE;
    endcase
  end

  // Transaction context captured at grant; app_cmd_o/app_addr_o come from
  // these registers so they stay stable through a stalled CMD.
  always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
    if (ui_reset_i) begin
      id_r   <= '0;
      rr_r   <= '0;
      cmd_r  <= WR;
      addr_r <= '0;
      beat_r <= '0;
    end else begin
      if (state_r == ARB_IDLE && arb_v) begin
        id_r   <= arb_id;
        cmd_r  <= client_cmd_i[arb_id];
        addr_r <= client_addr_i[arb_id];
        rr_r   <= (arb_id == lg_clients_lp'(num_clients_p - 1)) ? '0 : arb_id + 1'b1;
      end
      if (cmd_accept)
        beat_r <= '0;
      else if (wbeat_accept)
        beat_r <= beat_r + 1'b1;
    end
  end

  always_comb begin
    client_yumi_o       = '0;
    client_wdata_yumi_o = '0;
    app_en_o            = 1'b0;
    app_wdf_wren_o      = 1'b0;
    app_wdf_end_o       = 1'b0;
    unique case (state_r)
      ARB_IDLE:  client_yumi_o = arb_grants;
      ARB_CMD:   app_en_o = 1'b1;
      ARB_WDATA: begin
        app_wdf_wren_o            = client_wdata_v_i[id_r];
        app_wdf_end_o             = last_beat;
        client_wdata_yumi_o[id_r] = wbeat_accept;
      end
      default: ;
    endcase
  end

  assign app_cmd_o      = cmd_r;
  assign app_addr_o     = addr_r;
  assign app_wdf_data_o = client_wdata_i[id_r];
  assign app_wdf_mask_o = client_wmask_i[id_r];

  assign tag_push = cmd_accept & ~bsg_dmc_cmd_is_write(cmd_r);
  assign tag_pop  = app_rd_data_valid_i & app_rd_data_end_i;

  bsg_fifo_1r1w_small #(
    .width_p (lg_clients_lp),
    .els_p   (rd_tag_depth_p)
  ) tag_fifo (
    .clk_i   (ui_clk_i),
    .reset_i (ui_reset_i),
    .v_i     (tag_push),
    .data_i  (id_r),
    .ready_o (tag_ready),
    .v_o     (tag_v),
    .data_o  (tag_head),
    .yumi_i  (tag_pop)
  );

  // Read beats go straight to the oldest outstanding issuer; clients cannot stall.
  // A beat arriving with no outstanding read is dropped.
  always_comb begin
    client_rdata_v_o = '0;
    if (tag_v)
      client_rdata_v_o[tag_head] = app_rd_data_valid_i;
  end

  assign client_rdata_o      = app_rd_data_i;
  assign client_rdata_last_o = app_rd_data_end_i;

  rd_data_has_owner: assert property (@(posedge ui_clk_i) disable iff (ui_reset_i)
    app_rd_data_valid_i |-> tag_v);

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// tb_bsg_dmc_ui_arbiter
// Directed self-checking bench for bsg_dmc_ui_arbiter with 4 clients,
// 4-beat bursts and an 8-deep read tag FIFO. Inputs are driven 1 time unit
// after the rising edge and outputs are compared 1 unit later.
module tb_bsg_dmc_ui_arbiter;
  import bsg_dmc_pkg::*;

  logic                  ui_clk_i = 1'b0;
  logic                  ui_reset_i;
  logic     [3:0]        client_v_i;
  app_cmd_e [3:0]        client_cmd_i;
  logic     [3:0][27:0]  client_addr_i;
  logic     [3:0]        client_yumi_o;
  logic     [3:0]        client_wdata_v_i;
  logic     [3:0][31:0]  client_wdata_i;
  logic     [3:0][3:0]   client_wmask_i;
  logic     [3:0]        client_wdata_yumi_o;
  logic     [3:0]        client_rdata_v_o;
  logic     [31:0]       client_rdata_o;
  logic                  client_rdata_last_o;
  logic                  app_en_o;
  app_cmd_e              app_cmd_o;
  logic     [27:0]       app_addr_o;
  logic                  app_rdy_i;
  logic                  app_wdf_wren_o;
  logic     [31:0]       app_wdf_data_o;
  logic     [3:0]        app_wdf_mask_o;
  logic                  app_wdf_end_o;
  logic                  app_wdf_rdy_i;
  logic                  app_rd_data_valid_i;
  logic     [31:0]       app_rd_data_i;
  logic                  app_rd_data_end_i;

  int vectors     = 0;
  int miscompares = 0;

  bsg_dmc_ui_arbiter #(
    .num_clients_p      (4),
    .ui_addr_width_p    (28),
    .ui_data_width_p    (32),
    .burst_data_width_p (128),
    .rd_tag_depth_p     (8)
  ) dut (
    .ui_clk_i            (ui_clk_i),
    .ui_reset_i          (ui_reset_i),
    .client_v_i          (client_v_i),
    .client_cmd_i        (client_cmd_i),
    .client_addr_i       (client_addr_i),
    .client_yumi_o       (client_yumi_o),
    .client_wdata_v_i    (client_wdata_v_i),
    .client_wdata_i      (client_wdata_i),
    .client_wmask_i      (client_wmask_i),
    .client_wdata_yumi_o (client_wdata_yumi_o),
    .client_rdata_v_o    (client_rdata_v_o),
    .client_rdata_o      (client_rdata_o),
    .client_rdata_last_o (client_rdata_last_o),
    .app_en_o            (app_en_o),
    .app_cmd_o           (app_cmd_o),
    .app_addr_o          (app_addr_o),
    .app_rdy_i           (app_rdy_i),
    .app_wdf_wren_o      (app_wdf_wren_o),
    .app_wdf_data_o      (app_wdf_data_o),
    .app_wdf_mask_o      (app_wdf_mask_o),
    .app_wdf_end_o       (app_wdf_end_o),
    .app_wdf_rdy_i       (app_wdf_rdy_i),
    .app_rd_data_valid_i (app_rd_data_valid_i),
    .app_rd_data_i       (app_rd_data_i),
    .app_rd_data_end_i   (app_rd_data_end_i)
  );

  always #5 ui_clk_i = ~ui_clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Carries the currently driven inputs across one rising edge.
  task automatic applyStimulus();
    @(posedge ui_clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    client_v_i          = '0;
    client_wdata_v_i    = '0;
    for (int i = 0; i < 4; i++) begin
      client_cmd_i[i]   = WR;
      client_addr_i[i]  = '0;
      client_wdata_i[i] = '0;
      client_wmask_i[i] = '0;
    end
    app_rdy_i           = 1'b1;
    app_wdf_rdy_i       = 1'b1;
    app_rd_data_valid_i = 1'b0;
    app_rd_data_i       = '0;
    app_rd_data_end_i   = 1'b0;
  endtask

  task automatic reset_dut();
    ui_reset_i = 1'b1;
    clear_inputs();
    applyStimulus();
    applyStimulus();
    ui_reset_i = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_yumi"},  64'(client_yumi_o), 64'(0));
    checkOutput({tag, "_en"},    64'(app_en_o), 64'(0));
    checkOutput({tag, "_wren"},  64'(app_wdf_wren_o), 64'(0));
    checkOutput({tag, "_wyumi"}, 64'(client_wdata_yumi_o), 64'(0));
    checkOutput({tag, "_rv"},    64'(client_rdata_v_o), 64'(0));
  endtask

  // One 4-beat read burst from the dmc, expected at the client in exp_v.
  task automatic return_burst(input string tag, input logic [3:0] exp_v, input logic [31:0] base);
    for (int b = 0; b < 4; b++) begin
      app_rd_data_valid_i = 1'b1;
      app_rd_data_i       = base + 32'(b);
      app_rd_data_end_i   = (b == 3);
      #1;
      checkOutput({tag, "_rv"},   64'(client_rdata_v_o), 64'(exp_v));
      checkOutput({tag, "_rd"},   64'(client_rdata_o), 64'(base + 32'(b)));
      checkOutput({tag, "_last"}, 64'(client_rdata_last_o), 64'(b == 3));
      applyStimulus();
    end
    app_rd_data_valid_i = 1'b0;
    app_rd_data_end_i   = 1'b0;
  endtask

  // Full 4-beat write burst from client id with valid and rdy held high.
  task automatic write_burst(input string tag, input logic [1:0] id);
    logic [3:0] exp_onehot;
    exp_onehot = 4'b0001 << id;
    client_wdata_v_i[id] = 1'b1;
    app_wdf_rdy_i        = 1'b1;
    for (int b = 0; b < 4; b++) begin
      client_wdata_i[id] = 32'hC000_0000 | (32'(id) << 8) | 32'(b);
      client_wmask_i[id] = 4'(b + 1);
      #1;
      checkOutput({tag, "_wren"},  64'(app_wdf_wren_o), 64'(1));
      checkOutput({tag, "_wdata"}, 64'(app_wdf_data_o), 64'(32'hC000_0000 | (32'(id) << 8) | 32'(b)));
      checkOutput({tag, "_wmask"}, 64'(app_wdf_mask_o), 64'(4'(b + 1)));
      checkOutput({tag, "_wend"},  64'(app_wdf_end_o), 64'(b == 3));
      checkOutput({tag, "_wyumi"}, 64'(client_wdata_yumi_o), 64'(exp_onehot));
      applyStimulus();
    end
  endtask

  logic [1:0] exp_id;
  logic [7:0] pat_v, pat_r;
  int         beat;

  initial begin
    $display("[TB] bsg_dmc_ui_arbiter directed test start");

    // Reset state
    reset_dut();
    #1;
    check_quiet("reset");

    // Clients 0 and 2 read together: 0 first, then 2; bursts return in order
    client_cmd_i[0]  = RD;  client_addr_i[0] = 28'h0000100;
    client_cmd_i[2]  = RD;  client_addr_i[2] = 28'h0000200;
    client_v_i       = 4'b0101;
    #1;
    checkOutput("rd_grant0", 64'(client_yumi_o), 64'(4'b0001));
    checkOutput("rd_en_idle", 64'(app_en_o), 64'(0));
    applyStimulus();
    client_v_i = 4'b0100;
    #1;
    checkOutput("rd_cmd0_en",   64'(app_en_o), 64'(1));
    checkOutput("rd_cmd0_cmd",  64'(app_cmd_o), 64'(RD));
    checkOutput("rd_cmd0_addr", 64'(app_addr_o), 64'(28'h0000100));
    checkOutput("rd_cmd0_yumi", 64'(client_yumi_o), 64'(0));
    applyStimulus();
    #1;
    checkOutput("rd_grant2", 64'(client_yumi_o), 64'(4'b0100));
    applyStimulus();
    client_v_i = 4'b0000;
    #1;
    checkOutput("rd_cmd2_en",   64'(app_en_o), 64'(1));
    checkOutput("rd_cmd2_addr", 64'(app_addr_o), 64'(28'h0000200));
    applyStimulus();
    return_burst("rd_ret0", 4'b0001, 32'hD000_0000);
    return_burst("rd_ret2", 4'b0100, 32'hD100_0000);

    // All four clients hold WR: grants 0,1,2,3,0, four beats each
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      client_cmd_i[i]   = WR;
      client_addr_i[i]  = 28'h1000000 + 28'(i);
      client_wdata_i[i] = 32'hDEAD_0000 | 32'(i);
      client_wdata_v_i[i] = 1'b1;
    end
    client_v_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id = 2'(g % 4);
      #1;
      checkOutput("wr_grant", 64'(client_yumi_o), 64'(4'b0001 << exp_id));
      applyStimulus();
      #1;
      checkOutput("wr_cmd_en",   64'(app_en_o), 64'(1));
      checkOutput("wr_cmd_cmd",  64'(app_cmd_o), 64'(WR));
      checkOutput("wr_cmd_addr", 64'(app_addr_o), 64'(28'h1000000 + 28'(exp_id)));
      applyStimulus();
      write_burst("wr_all", exp_id);
    end
    client_v_i       = 4'b0000;
    client_wdata_v_i = 4'b0000;
    #1;
    check_quiet("wr_done");

    // Stalled command: app_rdy_i low for 5 cycles (rr pointer now at 1)
    client_cmd_i[1]  = RD;
    client_addr_i[1] = 28'h0ABCDEF;
    client_v_i       = 4'b0010;
    app_rdy_i        = 1'b0;
    #1;
    checkOutput("stall_grant", 64'(client_yumi_o), 64'(4'b0010));
    applyStimulus();
    for (int s = 0; s < 5; s++) begin
      client_addr_i[1] = 28'hFFF0000 + 28'(s);
      #1;
      checkOutput("stall_en",   64'(app_en_o), 64'(1));
      checkOutput("stall_cmd",  64'(app_cmd_o), 64'(RD));
      checkOutput("stall_addr", 64'(app_addr_o), 64'(28'h0ABCDEF));
      checkOutput("stall_yumi", 64'(client_yumi_o), 64'(0));
      applyStimulus();
    end
    app_rdy_i  = 1'b1;
    client_v_i = 4'b0000;
    #1;
    checkOutput("stall_accept_en",   64'(app_en_o), 64'(1));
    checkOutput("stall_accept_addr", 64'(app_addr_o), 64'(28'h0ABCDEF));
    applyStimulus();
    #1;
    checkOutput("stall_after_en", 64'(app_en_o), 64'(0));
    return_burst("stall_ret1", 4'b0010, 32'hD200_0000);

    // Client 3 write with irregular valid/rdy; client 0 also offers data (rr at 2)
    client_cmd_i[3]  = WR;
    client_addr_i[3] = 28'h3333333;
    client_v_i       = 4'b1000;
    client_wdata_v_i = 4'b0001;
    #1;
    checkOutput("gap_grant", 64'(client_yumi_o), 64'(4'b1000));
    applyStimulus();
    client_v_i = 4'b0000;
    #1;
    checkOutput("gap_cmd_addr", 64'(app_addr_o), 64'(28'h3333333));
    applyStimulus();
    pat_v = 8'b1110_1101;
    pat_r = 8'b1011_1011;
    beat  = 0;
    for (int c = 0; c < 8; c++) begin
      client_wdata_v_i[3] = pat_v[c];
      app_wdf_rdy_i       = pat_r[c];
      client_wdata_i[3]   = 32'h3000_0000 + 32'(beat);
      #1;
      checkOutput("gap_wren",  64'(app_wdf_wren_o), 64'(pat_v[c]));
      checkOutput("gap_wyumi", 64'(client_wdata_yumi_o), 64'((pat_v[c] & pat_r[c]) ? 4'b1000 : 4'b0000));
      checkOutput("gap_wend",  64'(app_wdf_end_o), 64'(beat == 3));
      if (pat_v[c])
        checkOutput("gap_wdata", 64'(app_wdf_data_o), 64'(32'h3000_0000 + 32'(beat)));
      applyStimulus();
      if (pat_v[c] & pat_r[c]) beat++;
    end
    client_wdata_v_i[3] = 1'b1;
    app_wdf_rdy_i       = 1'b1;
    #1;
    check_quiet("gap_done");
    client_wdata_v_i = 4'b0000;

    // Tag FIFO full: 9th read held back until a burst ends, then push+pop together
    reset_dut();
    client_cmd_i[0]  = RD;
    client_addr_i[0] = 28'h0000040;
    client_v_i       = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      #1;
      checkOutput("full_grant", 64'(client_yumi_o), 64'(4'b0001));
      applyStimulus();
      #1;
      checkOutput("full_cmd_en", 64'(app_en_o), 64'(1));
      applyStimulus();
    end
    for (int w = 0; w < 3; w++) begin
      #1;
      checkOutput("full_blocked_yumi", 64'(client_yumi_o), 64'(0));
      checkOutput("full_blocked_en",   64'(app_en_o), 64'(0));
      applyStimulus();
    end
    for (int b = 0; b < 4; b++) begin
      app_rd_data_valid_i = 1'b1;
      app_rd_data_i       = 32'hE000_0000 + 32'(b);
      app_rd_data_end_i   = (b == 3);
      #1;
      checkOutput("full_ret_rv",   64'(client_rdata_v_o), 64'(4'b0001));
      checkOutput("full_ret_yumi", 64'(client_yumi_o), 64'(0));
      applyStimulus();
    end
    app_rd_data_i     = 32'hE100_0000;
    app_rd_data_end_i = 1'b0;
    #1;
    checkOutput("full_grant9", 64'(client_yumi_o), 64'(4'b0001));
    checkOutput("full_b2_rv",  64'(client_rdata_v_o), 64'(4'b0001));
    applyStimulus();
    app_rdy_i     = 1'b0;
    app_rd_data_i = 32'hE100_0001;
    #1;
    checkOutput("full_cmd9_en", 64'(app_en_o), 64'(1));
    applyStimulus();
    app_rd_data_i = 32'hE100_0002;
    #1;
    checkOutput("full_cmd9_hold", 64'(app_en_o), 64'(1));
    applyStimulus();
    app_rdy_i         = 1'b1;
    app_rd_data_i     = 32'hE100_0003;
    app_rd_data_end_i = 1'b1;
    #1;
    checkOutput("full_pushpop_en",   64'(app_en_o), 64'(1));
    checkOutput("full_pushpop_last", 64'(client_rdata_last_o), 64'(1));
    applyStimulus();
    app_rd_data_valid_i = 1'b0;
    app_rd_data_end_i   = 1'b0;
    #1;
    checkOutput("full_grant10", 64'(client_yumi_o), 64'(4'b0001));
    applyStimulus();
    #1;
    checkOutput("full_cmd10_en", 64'(app_en_o), 64'(1));
    applyStimulus();
    #1;
    checkOutput("full_again_yumi", 64'(client_yumi_o), 64'(0));
    applyStimulus();
    #1;
    checkOutput("full_again_yumi2", 64'(client_yumi_o), 64'(0));
    client_v_i = 4'b0000;

    // Reset in the middle of a write burst, then a clean write
    reset_dut();
    client_cmd_i[2]  = WR;
    client_addr_i[2] = 28'h2222220;
    client_v_i       = 4'b0100;
    client_wdata_v_i = 4'b0100;
    #1;
    checkOutput("rst_grant2", 64'(client_yumi_o), 64'(4'b0100));
    applyStimulus();
    client_v_i = 4'b0000;
    #1;
    checkOutput("rst_cmd2_en", 64'(app_en_o), 64'(1));
    applyStimulus();
    for (int b = 0; b < 2; b++) begin
      client_wdata_i[2] = 32'h2000_0000 + 32'(b);
      #1;
      checkOutput("rst_beat_wren", 64'(app_wdf_wren_o), 64'(1));
      applyStimulus();
    end
    ui_reset_i = 1'b1;
    #1;
    check_quiet("rst_async");
    applyStimulus();
    check_quiet("rst_edge");
    ui_reset_i       = 1'b0;
    client_wdata_v_i = 4'b0000;
    client_cmd_i[1]  = WR;
    client_addr_i[1] = 28'h1111110;
    client_v_i       = 4'b0010;
    #1;
    checkOutput("rst_grant1", 64'(client_yumi_o), 64'(4'b0010));
    applyStimulus();
    client_v_i = 4'b0000;
    #1;
    checkOutput("rst_cmd1_en",   64'(app_en_o), 64'(1));
    checkOutput("rst_cmd1_addr", 64'(app_addr_o), 64'(28'h1111110));
    applyStimulus();
    write_burst("rst_wr1", 2'd1);
    #1;
    check_quiet("rst_wr1_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
